// File: rtl/lsu_dmem_port_if.sv
// Bundle for lsu_dmem_port: MEM-stage request/response channels plus the dmem
// bus. "slave" is the load/store port's view; "master" is the core/dmem side.
interface lsu_dmem_port_if;
    // Handshakes: a request transfers on a rising edge with req_valid && req_ready.
    // A response transfers on a rising edge with rsp_valid && rsp_ready. While
    // rsp_valid is high and rsp_ready is low, every rsp_* field holds its value.
    // req_ready depends only on port state. Stores are posted and produce no response.
    logic         req_valid;
    logic         req_ready;
    logic         req_we;
    logic         req_vec;
    logic [31:0]  req_addr;
    logic [15:0]  req_wdata_s;
    logic [255:0] req_wdata_v;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_vec;
    logic [15:0]  rsp_data_s;
    logic [255:0] rsp_data_v;
    logic         rsp_err;
    logic         st_err;

    logic         mem_w_enable;
    logic         mem_src_sel;
    logic [31:0]  mem_addr;
    logic [15:0]  mem_w_data_a;
    logic [255:0] mem_w_data_b;
    logic [15:0]  mem_q_a;
    logic [255:0] mem_q_b;

    modport slave (
        input  req_valid, req_we, req_vec, req_addr, req_wdata_s, req_wdata_v,
        input  rsp_ready, mem_q_a, mem_q_b,
        output req_ready, rsp_valid, rsp_vec, rsp_data_s, rsp_data_v, rsp_err, st_err,
        output mem_w_enable, mem_src_sel, mem_addr, mem_w_data_a, mem_w_data_b
    );

    modport master (
        output req_valid, req_we, req_vec, req_addr, req_wdata_s, req_wdata_v,
        output rsp_ready, mem_q_a, mem_q_b,
        input  req_ready, rsp_valid, rsp_vec, rsp_data_s, rsp_data_v, rsp_err, st_err,
        input  mem_w_enable, mem_src_sel, mem_addr, mem_w_data_a, mem_w_data_b
    );
endinterface

// File: rtl/lsu_dmem_port.sv
// Single-outstanding load/store port from the MEM stage to dmem, with registered
// dmem drive and a held load response. Define LSU_ALIGN_CHECK_EN to enable the alignment check.
module lsu_dmem_port #(
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lsu_dmem_port_if.slave       bus,
    output logic [1:0]           dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    // dmem samples at the edge that ends ISSUE and q is usable RD_LAT edges later,
    // so WAIT spans RD_LAT cycles and the response rises at E1+RD_LAT.
    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [1:0] cnt;
    logic [1:0] cnt_nxt;
    logic       ld_q;
    logic       accept;
    logic       misalign;
    logic       capture;
    logic       err_load;
    logic       err_store;

`ifdef LSU_ALIGN_CHECK_EN
    assign misalign = bus.req_vec ? (bus.req_addr[4:0] != 5'd0) : bus.req_addr[0];
`else
    assign misalign = 1'b0;
`endif

    assign dbg_state     = state;
    assign bus.rsp_valid = (state == RESP);

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        accept        = 1'b0;
        capture       = 1'b0;
        err_load      = 1'b0;
        err_store     = 1'b0;
        bus.req_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.req_ready = rst_n;
                if (bus.req_valid) begin
                    accept = 1'b1;
                    if (misalign) begin
                        if (bus.req_we) begin
                            err_store = 1'b1;
                        end else begin
                            err_load  = 1'b1;
                            state_nxt = RESP;
                        end
                    end else begin
                        state_nxt = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (ld_q) begin
                    state_nxt = WAIT;
                    cnt_nxt   = WAIT_INIT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (cnt == 2'd0) begin
                    state_nxt = RESP;
                    capture   = 1'b1;
                end else begin
                    cnt_nxt = cnt - 2'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 2'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_q             <= 1'b0;
            bus.mem_w_enable <= 1'b0;
            bus.mem_src_sel  <= 1'b0;
            bus.mem_addr     <= 32'd0;
            bus.mem_w_data_a <= 16'd0;
            bus.mem_w_data_b <= 256'd0;
            bus.rsp_vec      <= 1'b0;
            bus.rsp_data_s   <= 16'd0;
            bus.rsp_data_v   <= 256'd0;
            bus.rsp_err      <= 1'b0;
            bus.st_err       <= 1'b0;
        end else begin
            bus.mem_w_enable <= 1'b0;
            bus.st_err       <= err_store;
            if (accept && !misalign) begin
                ld_q             <= !bus.req_we;
                bus.mem_w_enable <= bus.req_we;
                bus.mem_src_sel  <= bus.req_vec;
                bus.mem_addr     <= bus.req_addr;
                // Only the selected write bus moves; the other keeps its last value.
                if (bus.req_we && bus.req_vec) begin
                    bus.mem_w_data_b <= bus.req_wdata_v;
                end
                if (bus.req_we && !bus.req_vec) begin
                    bus.mem_w_data_a <= bus.req_wdata_s;
                end
            end
            if (capture) begin
                bus.rsp_vec    <= bus.mem_src_sel;
                bus.rsp_err    <= 1'b0;
                bus.rsp_data_s <= bus.mem_src_sel ? 16'd0 : bus.mem_q_a;
                bus.rsp_data_v <= bus.mem_src_sel ? bus.mem_q_b : 256'd0;
            end else if (err_load) begin
                bus.rsp_vec    <= bus.req_vec;
                bus.rsp_err    <= 1'b1;
                bus.rsp_data_s <= 16'd0;
                bus.rsp_data_v <= 256'd0;
            end
        end
    end

    a_we_only_in_issue: assert property (@(posedge clk) disable iff (!rst_n)
        bus.mem_w_enable |-> (state == ISSUE));

    a_rsp_held: assert property (@(posedge clk) disable iff (!rst_n)
        (bus.rsp_valid && !bus.rsp_ready) |=>
        (bus.rsp_valid && $stable(bus.rsp_vec) && $stable(bus.rsp_err) &&
         $stable(bus.rsp_data_s) && $stable(bus.rsp_data_v)));

endmodule
